// File: rtl/my_logic_unit.sv
// my_logic_unit: registered bitwise logic unit with an AND-accumulator.
// One operand set is accepted per cycle under a valid/ready handshake.
// The result is held in a single output register together with its
// all-zero / all-ones flags until the downstream consumer takes it.
module my_logic_unit #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ones
);

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_NAND    = 3'b011;
  localparam logic [2:0] OP_NOR     = 3'b100;
  localparam logic [2:0] OP_XNOR    = 3'b101;
  localparam logic [2:0] OP_ACC_AND = 3'b110;
  localparam logic [2:0] OP_ACC_CLR = 3'b111;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res_p0;
  logic             accept_p0;

  // Pure per-bit operation; ACC_CLR passes operand A through.
  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [WIDTH-1:0] acc_val
  );
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:     r = x & y;
      OP_OR:      r = x | y;
      OP_XOR:     r = x ^ y;
      OP_NAND:    r = ~(x & y);
      OP_NOR:     r = ~(x | y);
      OP_XNOR:    r = ~(x ^ y);
      OP_ACC_AND: r = acc_val & x & y;
      OP_ACC_CLR: r = x;
      default:    r = '0;
    endcase
    return r;
  endfunction

  // ---- stage p0: handshake and combinational result ----
  // Reset forces ready so upstream never stalls on a stale held result.
  assign in_ready  = reset || !out_valid || out_ready;
  assign accept_p0 = in_valid && in_ready;
  assign res_p0    = logic_op(op, a, b, acc);

  // ---- stage p1: output register, flags and accumulator ----
  // Output register: load on accept, drain on out_ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      zero      <= 1'b1;
      ones      <= 1'b0;
    end else if (accept_p0) begin
      out_valid <= 1'b1;
      out       <= res_p0;
      zero      <= (res_p0 == {WIDTH{1'b0}});
      ones      <= (res_p0 == {WIDTH{1'b1}});
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator: only accepted ACC_AND / ACC_CLR touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= ACC_INIT;
    end else if (accept_p0) begin
      if (op == OP_ACC_AND) begin
        acc <= res_p0;
      end else if (op == OP_ACC_CLR) begin
        acc <= ACC_INIT;
      end
    end
  end

endmodule

// File: tb/tb_my_logic_unit.sv
// Bench for my_logic_unit: directed WIDTH=8 scenarios plus randomised
// WIDTH=1 and WIDTH=32 instances checked against an independent model.
module tb_my_logic_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8 instance
  logic       in_valid, in_ready, out_valid, out_ready, zero, ones;
  logic [7:0] a, b, out;
  logic [2:0] op;

  my_logic_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .ones(ones)
  );

  // WIDTH=1 instance
  logic       iv_w1, ir_w1, ov_w1, or_w1, z_w1, o_w1;
  logic [0:0] a_w1, b_w1, out_w1;
  logic [2:0] op_w1;

  my_logic_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv_w1), .in_ready(ir_w1),
    .a(a_w1), .b(b_w1), .op(op_w1), .out_valid(ov_w1), .out_ready(or_w1),
    .out(out_w1), .zero(z_w1), .ones(o_w1)
  );

  // WIDTH=32 instance
  logic        iv_w32, ir_w32, ov_w32, or_w32, z_w32, o_w32;
  logic [31:0] a_w32, b_w32, out_w32;
  logic [2:0]  op_w32;

  my_logic_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv_w32), .in_ready(ir_w32),
    .a(a_w32), .b(b_w32), .op(op_w32), .out_valid(ov_w32), .out_ready(or_w32),
    .out(out_w32), .zero(z_w32), .ones(o_w32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 3'b000; out_ready = 1'b1;
    iv_w1 = 1'b0; a_w1 = 1'b0; b_w1 = 1'b0; op_w1 = 3'b000; or_w1 = 1'b1;
    iv_w32 = 1'b0; a_w32 = '0; b_w32 = '0; op_w32 = 3'b000; or_w32 = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Present one operand set for one cycle with out_ready high.
  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b1;
    in_valid = 1'b1; op = 3'b001; a = 8'hFF; b = 8'hFF; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_during: got %b expected 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", zero); end
    checks++; if (ones !== 1'b0) begin errors++; $display("FAIL reset_ones: got %b expected 0", ones); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp [6];
    exp[0] = 8'h24; exp[1] = 8'hBD; exp[2] = 8'h99;
    exp[3] = 8'hDB; exp[4] = 8'h42; exp[5] = 8'h66;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = 8'hA5; b = 8'h3C; op = 3'(i);
      tick();
      checks++; if (out !== exp[i]) begin errors++; $display("FAIL sweep_out op=%0d: got %h expected %h", i, out, exp[i]); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid op=%0d: got %b expected 1", i, out_valid); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    checks++; if (out !== 8'h66) begin errors++; $display("FAIL drain_keeps_out: got %h expected 66", out); end
  endtask

  task automatic test_acc_chain();
    do_reset();
    send(3'b110, 8'hF0, 8'hFF);
    checks++; if (out !== 8'hF0) begin errors++; $display("FAIL acc_step1: got %h expected F0", out); end
    send(3'b110, 8'h3C, 8'hFF);
    checks++; if (out !== 8'h30) begin errors++; $display("FAIL acc_step2: got %h expected 30", out); end
    // Non-accumulating op and an unaccepted ACC_AND must leave acc at 30.
    send(3'b000, 8'h00, 8'hFF);
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL acc_plain_and: got %h expected 00", out); end
    in_valid = 1'b0; op = 3'b110; a = 8'h00; b = 8'h00;
    tick();
    send(3'b110, 8'hFF, 8'hFF);
    checks++; if (out !== 8'h30) begin errors++; $display("FAIL acc_unchanged: got %h expected 30", out); end
    send(3'b111, 8'h11, 8'h00);
    checks++; if (out !== 8'h11) begin errors++; $display("FAIL acc_clr: got %h expected 11", out); end
    send(3'b110, 8'h0F, 8'hFF);
    checks++; if (out !== 8'h0F) begin errors++; $display("FAIL acc_after_clr: got %h expected 0F", out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    send(3'b000, 8'hA5, 8'h3C);
    checks++; if (out !== 8'h24) begin errors++; $display("FAIL bp_first: got %h expected 24", out); end
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b001; a = 8'hA5; b = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d: got %b expected 0", i, in_ready); end
      tick();
      checks++; if (out !== 8'h24) begin errors++; $display("FAIL bp_hold_out cyc=%0d: got %h expected 24", i, out); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d: got %b expected 1", i, out_valid); end
      checks++; if (zero !== 1'b0 || ones !== 1'b0) begin errors++; $display("FAIL bp_hold_flags cyc=%0d: got %b%b expected 00", i, zero, ones); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    tick();
    checks++; if (out !== 8'hBD) begin errors++; $display("FAIL bp_new_out: got %h expected BD", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: got %b expected 1", out_valid); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: got %b expected 0", out_valid); end
  endtask

  task automatic test_flags();
    send(3'b000, 8'h00, 8'hFF);
    checks++; if (out !== 8'h00 || zero !== 1'b1 || ones !== 1'b0) begin errors++; $display("FAIL flags_zero: got out=%h z=%b o=%b expected 00 1 0", out, zero, ones); end
    send(3'b101, 8'h5A, 8'h5A);
    checks++; if (out !== 8'hFF || zero !== 1'b0 || ones !== 1'b1) begin errors++; $display("FAIL flags_ones: got out=%h z=%b o=%b expected FF 0 1", out, zero, ones); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    send(3'b110, 8'hF0, 8'hFF);
    checks++; if (out !== 8'hF0) begin errors++; $display("FAIL mid_pre: got %h expected F0", out); end
    reset = 1'b1; in_valid = 1'b1; op = 3'b110; a = 8'h0F; b = 8'hFF; out_ready = 1'b0;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out !== 8'h00 || zero !== 1'b1) begin errors++; $display("FAIL mid_reset: got v=%b out=%h z=%b expected 0 00 1", out_valid, out, zero); end
    send(3'b110, 8'hFF, 8'hFF);
    checks++; if (out !== 8'hFF) begin errors++; $display("FAIL mid_acc_init: got %h expected FF", out); end
  endtask

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x,
                                         input logic [63:0] y, input logic [63:0] acc,
                                         input logic [63:0] mask);
    logic [63:0] r;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x & y);
      3'd4: r = ~(x | y);
      3'd5: r = ~(x ^ y);
      3'd6: r = acc & x & y;
      default: r = x;
    endcase
    return r & mask;
  endfunction

  task automatic test_random_widths();
    logic [63:0] mask1, mask32, m1_out, m1_acc, m32_out, m32_acc;
    logic        m1_vld, m32_vld, acc1, acc32, rdy1, rdy32;
    mask1 = 64'h1; mask32 = 64'hFFFF_FFFF;
    idle_all();
    do_reset();
    m1_out = '0; m1_acc = mask1; m1_vld = 1'b0;
    m32_out = '0; m32_acc = mask32; m32_vld = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      iv_w1 = 1'($urandom_range(0, 1)); a_w1 = 1'($urandom); b_w1 = 1'($urandom);
      op_w1 = 3'($urandom); or_w1 = 1'($urandom_range(0, 1));
      iv_w32 = 1'($urandom_range(0, 1)); a_w32 = $urandom; b_w32 = $urandom;
      op_w32 = 3'($urandom); or_w32 = 1'($urandom_range(0, 1));
      if (($urandom_range(0, 3) == 0) && op_w32[2:1] != 2'b11) op_w32 = 3'b110;
      rdy1  = !m1_vld || or_w1;
      rdy32 = !m32_vld || or_w32;
      #1;
      checks++; if (ir_w1 !== rdy1) begin errors++; $display("FAIL w1_in_ready cyc=%0d: got %b expected %b", i, ir_w1, rdy1); end
      checks++; if (ir_w32 !== rdy32) begin errors++; $display("FAIL w32_in_ready cyc=%0d: got %b expected %b", i, ir_w32, rdy32); end
      acc1  = iv_w1 && rdy1;
      acc32 = iv_w32 && rdy32;
      if (acc1) begin
        m1_out = ref_op(op_w1, {63'b0, a_w1}, {63'b0, b_w1}, m1_acc, mask1);
        m1_vld = 1'b1;
        if (op_w1 == 3'd6) m1_acc = m1_out;
        else if (op_w1 == 3'd7) m1_acc = mask1;
      end else if (or_w1) begin
        m1_vld = 1'b0;
      end
      if (acc32) begin
        m32_out = ref_op(op_w32, {32'b0, a_w32}, {32'b0, b_w32}, m32_acc, mask32);
        m32_vld = 1'b1;
        if (op_w32 == 3'd6) m32_acc = m32_out;
        else if (op_w32 == 3'd7) m32_acc = mask32;
      end else if (or_w32) begin
        m32_vld = 1'b0;
      end
      tick();
      checks++; if (ov_w1 !== m1_vld || {63'b0, out_w1} !== m1_out || z_w1 !== (m1_out == 64'd0) || o_w1 !== (m1_out == mask1)) begin
        errors++; $display("FAIL w1_result cyc=%0d: got v=%b out=%h z=%b o=%b expected v=%b out=%h", i, ov_w1, out_w1, z_w1, o_w1, m1_vld, m1_out);
      end
      checks++; if (ov_w32 !== m32_vld || {32'b0, out_w32} !== m32_out || z_w32 !== (m32_out == 64'd0) || o_w32 !== (m32_out == mask32)) begin
        errors++; $display("FAIL w32_result cyc=%0d: got v=%b out=%h z=%b o=%b expected v=%b out=%h", i, ov_w32, out_w32, z_w32, o_w32, m32_vld, m32_out);
      end
    end
    idle_all();
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_op_sweep();
    test_acc_chain();
    test_backpressure();
    test_flags();
    test_reset_midstream();
    test_random_widths();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
